// File: rtl/fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit
//
// Instruction-fetch stage. It owns the architectural PC and reads one word at
// a time from instruction memory (req/gnt/rvalid). It holds one fetched
// instruction for decode (valid/ready). When decode consumes the entry, the
// PC loads the next-PC value computed downstream.
//
// A misaligned next-PC does not go to memory. It becomes a nop entry
// (instr = 0, fetch_err = 1) that carries the offending PC. This keeps decode
// in charge of raising the exception.
//
// Ports
//   clk          in   1      system clock, all state on rising edge
//   reset        in   1      asynchronous reset, active low
//   imem_req     out  1      instruction read request (registered)
//   imem_addr    out  32     word address of the request, equals pc
//   imem_gnt     in   1      memory accepts the request this cycle
//   imem_rvalid  in   1      read data valid
//   imem_rdata   in   32     instruction word
//   pc           out  32     address of the buffered / in-flight instruction
//   pc_plus4     out  32     pc + 4 (combinational, wraps)
//   instr        out  32     buffered instruction
//   instr_valid  out  1      instr/pc valid for decode
//   instr_ready  in   1      decode consumes instr this cycle
//   npc          in   32     next PC, sampled only in the consume cycle
//   fetch_err    out  1      buffered entry is an address-error nop
//   retire_cnt   out  CNT_W  number of consumed entries (wraps)
// ---------------------------------------------------------------------------
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic [31:0]      instr,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic [31:0]      npc,
  output logic             fetch_err,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [1:0] {
    ST_REQ      = 2'd0,
    ST_WAIT_RSP = 2'd1,
    ST_HOLD     = 2'd2,
    ST_ERR      = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic             instr_valid_q, instr_valid_d;
  logic             fetch_err_q, fetch_err_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic             imem_req_q, imem_req_d;
  logic             consume_s;
  logic             npc_aligned_s;

  assign consume_s     = instr_valid_q & instr_ready;
  assign npc_aligned_s = (npc[1:0] == 2'b00);

  // Next-state and datapath update for the fetch FSM.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    fetch_err_d   = fetch_err_q;
    retire_cnt_d  = retire_cnt_q;

    case (state_q)
      ST_REQ: begin
        // The grant only counts while our request is actually on the bus.
        // This matters in the first cycle after reset, when imem_req is
        // still low because it is registered.
        if (imem_req_q && imem_gnt) begin
          state_d = ST_WAIT_RSP;
        end else begin
          state_d = ST_REQ;
        end
      end

      ST_WAIT_RSP: begin
        if (imem_rvalid) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          fetch_err_d   = 1'b0;
          state_d       = ST_HOLD;
        end else begin
          state_d = ST_WAIT_RSP;
        end
      end

      ST_HOLD: begin
        if (consume_s) begin
          retire_cnt_d  = retire_cnt_q + CNT_ONE;
          pc_d          = npc;
          instr_valid_d = 1'b0;
          if (npc_aligned_s) begin
            state_d = ST_REQ;
          end else begin
            state_d = ST_ERR;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end

      ST_ERR: begin
        // Hand decode a nop tagged with the error. pc already holds the
        // misaligned target.
        instr_d       = 32'h0000_0000;
        fetch_err_d   = 1'b1;
        instr_valid_d = 1'b1;
        state_d       = ST_HOLD;
      end

      default: begin
        // Unreachable encoding: drop any buffered entry and refetch at pc.
        instr_valid_d = 1'b0;
        state_d       = ST_REQ;
      end
    endcase

    // The request is registered. It is high exactly while the FSM sits in
    // REQ, and low during reset.
    imem_req_d = (state_d == ST_REQ);
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_REQ;
      pc_q          <= RESET_PC;
      instr_q       <= 32'h0000_0000;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      retire_cnt_q  <= {CNT_W{1'b0}};
      imem_req_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      fetch_err_q   <= fetch_err_d;
      retire_cnt_q  <= retire_cnt_d;
      imem_req_q    <= imem_req_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign fetch_err   = fetch_err_q;
  assign retire_cnt  = retire_cnt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_pc_unit
//
// Directed bench for fetch_pc_unit. A small memory responder grants requests
// when enabled and returns data one cycle after the grant. Words come from a
// bench-owned content function.
//
// The table drives a chain of consumes with hand-picked npc values and lists
// the expected buffered entry and retire count for each. Hand-written
// sequences cover grant withholding, decode back-pressure, reset during a
// read, and counter wrap.
//
// Counter wrap uses a second instance with a 3-bit counter. It shares every
// input with the main instance, so its count must equal the main count
// modulo 8.
// ---------------------------------------------------------------------------
module tb_fetch_pc_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] npc;
  logic        fetch_err;
  logic [31:0] retire_cnt;

  logic        s_imem_req;
  logic [31:0] s_imem_addr;
  logic [31:0] s_pc;
  logic [31:0] s_pc_plus4;
  logic [31:0] s_instr;
  logic        s_instr_valid;
  logic        s_fetch_err;
  logic [2:0]  s_retire_cnt;

  int          n_cmp;
  int          n_fail;

  logic        auto_gnt;
  logic        force_rv;
  logic        rsp_pend;
  logic [31:0] rsp_addr;

  fetch_pc_unit #(.RESET_PC(32'h0000_3000), .CNT_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .npc         (npc),
    .fetch_err   (fetch_err),
    .retire_cnt  (retire_cnt)
  );

  fetch_pc_unit #(.RESET_PC(32'h0000_3000), .CNT_W(3)) dut_small (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (s_imem_req),
    .imem_addr   (s_imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .pc          (s_pc),
    .pc_plus4    (s_pc_plus4),
    .instr       (s_instr),
    .instr_valid (s_instr_valid),
    .instr_ready (instr_ready),
    .npc         (npc),
    .fetch_err   (s_fetch_err),
    .retire_cnt  (s_retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] exp_pc;
    logic        exp_err;
    logic [31:0] npc;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vec [9];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_3000) begin
      return 32'h3402_0005;
    end else begin
      return ~a;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive the memory side, step the clock, then settle.
  task automatic cyc();
    logic        nx_pend;
    logic [31:0] nx_addr;
    imem_gnt    = auto_gnt & imem_req;
    imem_rvalid = rsp_pend | force_rv;
    imem_rdata  = rsp_pend ? mem_word(rsp_addr) : 32'hDEAD_BEEF;
    nx_pend     = imem_gnt;
    nx_addr     = imem_addr;
    @(posedge clk);
    #1;
    rsp_pend = nx_pend;
    rsp_addr = nx_addr;
  endtask

  // Wait for instr_valid, up to 20 cycles. Returns cycles taken and whether
  // a request was seen on the way.
  task automatic wait_valid(output int n, output logic saw_req);
    n       = 0;
    saw_req = 1'b0;
    while (!instr_valid && n < 20) begin
      saw_req = saw_req | imem_req;
      cyc();
      n++;
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_pc"},    pc,                 32'h0000_3000);
    chk({tag, "_instr"}, instr,              32'h0000_0000);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_err"},   {31'd0, fetch_err},   32'd0);
    chk({tag, "_cnt"},   retire_cnt,         32'd0);
    chk({tag, "_req"},   {31'd0, imem_req},    32'd0);
  endtask

  initial begin
    int          n;
    logic        saw;
    logic [31:0] exp_instr;

    n_cmp  = 0;
    n_fail = 0;

    // pc, err, npc consumed, retire count after the consume
    vec[0] = '{32'h0000_3000, 1'b0, 32'h0000_3004, 32'd1};
    vec[1] = '{32'h0000_3004, 1'b0, 32'h0000_3010, 32'd2};
    vec[2] = '{32'h0000_3010, 1'b0, 32'h0000_3006, 32'd3};
    vec[3] = '{32'h0000_3006, 1'b1, 32'h0000_3000, 32'd4};
    vec[4] = '{32'h0000_3000, 1'b0, 32'h0000_3003, 32'd5};
    vec[5] = '{32'h0000_3003, 1'b1, 32'h0000_3001, 32'd6};
    vec[6] = '{32'h0000_3001, 1'b1, 32'h0000_3008, 32'd7};
    vec[7] = '{32'h0000_3008, 1'b0, 32'hFFFF_FFFC, 32'd8};
    vec[8] = '{32'hFFFF_FFFC, 1'b0, 32'h0000_3000, 32'd9};

    reset       = 1'b0;
    auto_gnt    = 1'b0;
    force_rv    = 1'b0;
    rsp_pend    = 1'b0;
    rsp_addr    = 32'h0;
    instr_ready = 1'b0;
    npc         = 32'h0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;

    cyc();
    cyc();
    check_reset_state("rst");

    // Release reset. The request appears one cycle later. The grant is
    // withheld for 4 cycles and given on the 5th.
    reset = 1'b1;
    cyc();
    for (int k = 0; k < 4; k++) begin
      chk("gnt_wait_req",   {31'd0, imem_req},    32'd1);
      chk("gnt_wait_addr",  imem_addr,            32'h0000_3000);
      chk("gnt_wait_valid", {31'd0, instr_valid}, 32'd0);
      cyc();
    end
    auto_gnt = 1'b1;
    cyc();
    chk("wait_rsp_req", {31'd0, imem_req}, 32'd0);
    cyc();

    // Table-driven consume chain
    for (int i = 0; i < 9; i++) begin
      wait_valid(n, saw);
      if (i > 0) begin
        chk("tbl_latency", n, vec[i].exp_err ? 32'd1 : 32'd2);
        chk("tbl_req_seen", {31'd0, saw}, {31'd0, ~vec[i].exp_err});
      end
      exp_instr = vec[i].exp_err ? 32'h0000_0000 : mem_word(vec[i].exp_pc);
      chk("tbl_valid", {31'd0, instr_valid}, 32'd1);
      chk("tbl_pc",    pc,                   vec[i].exp_pc);
      chk("tbl_pc4",   pc_plus4,             vec[i].exp_pc + 32'd4);
      chk("tbl_instr", instr,                exp_instr);
      chk("tbl_err",   {31'd0, fetch_err},   {31'd0, vec[i].exp_err});
      if (vec[i].exp_pc == 32'hFFFF_FFFC) begin
        chk("pc4_wrap", pc_plus4, 32'h0000_0000);
      end
      npc         = vec[i].npc;
      instr_ready = 1'b1;
      cyc();
      instr_ready = 1'b0;
      chk("tbl_cnt",      retire_cnt,             vec[i].exp_cnt);
      chk("tbl_cnt_w3",   {29'd0, s_retire_cnt},  vec[i].exp_cnt & 32'h7);
      chk("tbl_npc_load", pc,                     vec[i].npc);
      chk("tbl_cleared",  {31'd0, instr_valid},   32'd0);
    end

    // Back-pressure: decode stalls 5 cycles while npc toggles.
    wait_valid(n, saw);
    chk("bp_valid0", {31'd0, instr_valid}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      npc = k[0] ? 32'h0000_3004 : 32'h0000_3006;
      cyc();
      chk("bp_instr", instr,                32'h3402_0005);
      chk("bp_pc",    pc,                   32'h0000_3000);
      chk("bp_valid", {31'd0, instr_valid}, 32'd1);
      chk("bp_cnt",   retire_cnt,           32'd9);
    end
    npc         = 32'h0000_3010;
    instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
    npc         = 32'h0000_3004;
    chk("bp_pc_load", pc,         32'h0000_3010);
    chk("bp_cnt_inc", retire_cnt, 32'd10);

    // Reset in WAIT_RSP, then a stray rvalid after release.
    cyc();
    chk("pre_rst_req", {31'd0, imem_req}, 32'd0);
    reset    = 1'b0;
    rsp_pend = 1'b0;
    #1;
    check_reset_state("mid_rst");
    cyc();
    reset    = 1'b1;
    auto_gnt = 1'b0;
    force_rv = 1'b1;
    cyc();
    force_rv = 1'b0;
    chk("stray_valid", {31'd0, instr_valid}, 32'd0);
    chk("stray_instr", instr,                32'h0000_0000);
    chk("stray_pc",    pc,                   32'h0000_3000);
    chk("stray_cnt",   retire_cnt,           32'd0);
    chk("stray_req",   {31'd0, imem_req},    32'd1);
    chk("stray_addr",  imem_addr,            32'h0000_3000);
    auto_gnt = 1'b1;
    wait_valid(n, saw);
    chk("refetch_lat",   n,     32'd2);
    chk("refetch_instr", instr, 32'h3402_0005);
    chk("refetch_pc",    pc,    32'h0000_3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
